// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg: edge type encodings, default channel count and a constant clog2 for edge_event_arbiter
package edge_arb_pkg;
  localparam logic EVT_FALL = 1'b0;
  localparam logic EVT_RISE = 1'b1;
  localparam int N_CH_DEF = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/edge_arb_ch.sv
// edge_arb_ch: per-channel edge detect, sticky pending events and overflow flag
//   clk, rst    : clock, synchronous active-high reset
//   d_i         : input line, synchronous to clk
//   gnt_i       : arbiter serves this channel this cycle (type given by rise_o)
//   ovf_clr_i   : clear pulse for the overflow flag
//   rise_o      : type served on grant, older one first (EDGE_ARB_FALLING_EN only)
//   req_o       : some event is pending
//   ovf_o       : sticky overflow, an edge merged into an already pending one
// EDGE_ARB_FALLING_EN builds the falling-edge path.
module edge_arb_ch
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  input  logic gnt_i,
  input  logic ovf_clr_i,
`ifdef EDGE_ARB_FALLING_EN
  output logic rise_o,
`endif
  output logic req_o,
  output logic ovf_o
);
  logic d_buff_q;
  logic rise_edge;
  logic rise_pend_q, rise_pend_d;
  logic ovf_q, ovf_d, ovf_set;
  assign rise_edge = d_i & ~d_buff_q;
`ifdef EDGE_ARB_FALLING_EN
  logic fall_edge;
  logic fall_pend_q, fall_pend_d;
  logic older_rise_q, older_rise_d;
  logic gnt_rise, gnt_fall;
  assign fall_edge = ~d_i & d_buff_q;
  assign rise_o = rise_pend_q & (~fall_pend_q | older_rise_q);
  assign req_o = rise_pend_q | fall_pend_q;
  assign gnt_rise = gnt_i & rise_o;
  assign gnt_fall = gnt_i & ~rise_o;
  // a new edge sets its bit even when that type is granted now (set beats clear)
  always_comb begin
    rise_pend_d = rise_edge | (rise_pend_q & ~gnt_rise);
    fall_pend_d = fall_edge | (fall_pend_q & ~gnt_fall);
    older_rise_d = (rise_edge & fall_pend_d) ? EVT_FALL :
                   (fall_edge & rise_pend_d) ? EVT_RISE : older_rise_q;
    ovf_set = (rise_edge & rise_pend_q & ~gnt_rise) | (fall_edge & fall_pend_q & ~gnt_fall);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fall_pend_q <= 1'b0;
      older_rise_q <= 1'b0;
    end else begin
      fall_pend_q <= fall_pend_d;
      older_rise_q <= older_rise_d;
    end
  end
`else
  assign req_o = rise_pend_q;
  always_comb begin
    rise_pend_d = rise_edge | (rise_pend_q & ~gnt_i);
    ovf_set = rise_edge & rise_pend_q & ~gnt_i;
  end
`endif
  assign ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
  assign ovf_o = ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      d_buff_q <= 1'b0;
      rise_pend_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      d_buff_q <= d_i;
      rise_pend_q <= rise_pend_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: round-robin serialiser of per-channel edge events onto a valid/ready stream
//   clk, rst   : clock, synchronous active-high reset
//   d_i        : N_CH input lines, synchronous to clk
//   evt_valid  : event presented;  evt_ready : consumer accepts it
//   evt_ch     : channel of the event;  evt_rise : 1 rising, 0 falling
//   ovf_o      : sticky per-channel overflow;  ovf_clr_i : per-channel clear
// EDGE_ARB_FALLING_EN adds falling-edge events; otherwise evt_rise is tied to 1.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int ID_W = clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] d_i,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] ovf_o,
  input  logic [N_CH-1:0] ovf_clr_i
);
  logic [N_CH-1:0] req, gnt;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, evt_ch_q, evt_ch_d, sel;
  logic evt_valid_q, evt_valid_d, found, load, take;
  int idx;
  if (ID_W != clog2(N_CH)) begin : g_bad_id_w
    $error("edge_event_arbiter: ID_W must equal clog2(N_CH)");
  end
`ifdef EDGE_ARB_FALLING_EN
  logic [N_CH-1:0] serve_rise;
  logic evt_rise_q, evt_rise_d;
`endif
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    edge_arb_ch u_ch (
      .clk       (clk),
      .rst       (rst),
      .d_i       (d_i[c]),
      .gnt_i     (gnt[c]),
      .ovf_clr_i (ovf_clr_i[c]),
`ifdef EDGE_ARB_FALLING_EN
      .rise_o    (serve_rise[c]),
`endif
      .req_o     (req[c]),
      .ovf_o     (ovf_o[c])
    );
  end
  // first requester strictly after rr_ptr, wrapping; rr_ptr itself is checked last
  always_comb begin
    found = 1'b0;
    sel = rr_ptr_q;
    idx = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_CH;
      if (!found && req[ID_W'(idx)]) begin
        found = 1'b1;
        sel = ID_W'(idx);
      end
    end
  end
  assign load = !evt_valid_q || evt_ready;
  assign take = load && found;
  assign gnt = take ? (N_CH'(1) << sel) : '0;
  always_comb begin
    evt_valid_d = load ? found : evt_valid_q;
    evt_ch_d = take ? sel : evt_ch_q;
    rr_ptr_d = take ? sel : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_ch_q <= '0;
      rr_ptr_q <= ID_W'(N_CH - 1);
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_ch_q <= evt_ch_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
`ifdef EDGE_ARB_FALLING_EN
  assign evt_rise_d = take ? serve_rise[sel] : evt_rise_q;
  always_ff @(posedge clk) begin
    if (rst) evt_rise_q <= EVT_FALL;
    else evt_rise_q <= evt_rise_d;
  end
  assign evt_rise = evt_rise_q;
`else
  assign evt_rise = EVT_RISE;
`endif
  assign evt_valid = evt_valid_q;
  assign evt_ch = evt_ch_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed scenarios plus random traffic against an ordered-pending-list model
module tb_edge_event_arbiter;
  localparam int N = 4;
  localparam int W = 2;
`ifdef EDGE_ARB_FALLING_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] d = '0;
  logic [N-1:0] clr = '0;
  logic rdy = 1'b0;
  logic evt_valid, evt_rise;
  logic [W-1:0] evt_ch;
  logic [N-1:0] ovf;
  int total = 0;
  int bad = 0;
  bit m_slot [N][2];
  int m_len [N];
  bit [N-1:0] m_prev, m_ovf;
  bit m_valid, m_rise;
  int m_ch, m_rr;
  always #5 clk = ~clk;
  edge_event_arbiter #(.N_CH(N), .ID_W(W)) dut (
    .clk(clk), .rst(rst), .d_i(d), .evt_valid(evt_valid), .evt_ready(rdy),
    .evt_ch(evt_ch), .evt_rise(evt_rise), .ovf_o(ovf), .ovf_clr_i(clr)
  );
  // advance the model by one clock using the current inputs, then step the DUT
  task automatic tick();
    bit [N-1:0] set;
    if (rst) begin
      for (int c = 0; c < N; c++) m_len[c] = 0;
      m_prev = '0; m_ovf = '0; m_valid = 0; m_ch = 0; m_rise = !FE; m_rr = N - 1;
    end else begin
      if (!m_valid || rdy) begin
        m_valid = 0;
        for (int i = 1; i <= N; i++) begin
          int c = (m_rr + i) % N;
          if (!m_valid && m_len[c] > 0) begin
            m_valid = 1; m_ch = c; m_rise = m_slot[c][0];
            m_slot[c][0] = m_slot[c][1]; m_len[c]--; m_rr = c;
          end
        end
      end
      set = '0;
      for (int c = 0; c < N; c++) begin
        if (d[c] != m_prev[c] && (FE || d[c])) begin
          if ((m_len[c] > 0 && m_slot[c][0] == d[c]) || (m_len[c] > 1 && m_slot[c][1] == d[c])) set[c] = 1;
          else begin m_slot[c][m_len[c]] = d[c]; m_len[c]++; end
        end
      end
      m_ovf = (m_ovf & ~clr) | set;
      m_prev = d;
    end
    @(posedge clk); #1;
  endtask
  task automatic apply_reset();
    rst = 1; d = '0; clr = '0; rdy = 0;
    tick(); tick();
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1; d = '0; clr = '0; rdy = 0;
    tick(); tick();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
    total++; if (evt_ch !== '0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", evt_ch); end
    total++; if (evt_rise !== !FE) begin bad++; $display("FAIL reset_rise got=%b exp=%b", evt_rise, !FE); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL reset_ovf got=%b exp=0000", ovf); end
    rst = 0;
  endtask
  task automatic test_release();
    apply_reset();
    rdy = 1; tick();
    d = 4'b0100; tick();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rel_early got=%b exp=0", evt_valid); end
    tick();
    total++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd2, 1'b1}) begin bad++; $display("FAIL rel_event got=v%b ch%0d r%b exp=v1 ch2 r1", evt_valid, evt_ch, evt_rise); end
    tick();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rel_once got=%b exp=0", evt_valid); end
  endtask
  task automatic test_back_to_back();
    int exp_ch [3] = '{0, 1, 3};
    apply_reset();
    rdy = 1; tick();
    d = 4'b1011; tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({evt_valid, evt_ch} !== {1'b1, W'(exp_ch[i])}) begin bad++; $display("FAIL b2b_%0d got=v%b ch%0d exp=v1 ch%0d", i, evt_valid, evt_ch, exp_ch[i]); end
    end
    tick();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", evt_valid); end
  endtask
  task automatic test_backpressure();
    apply_reset();
    d = 4'b0010; tick(); tick();
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 4'b0110 : 4'b0010;
      tick();
      total++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd1, 1'b1}) begin bad++; $display("FAIL bp_hold_%0d got=v%b ch%0d r%b exp=v1 ch1 r1", i, evt_valid, evt_ch, evt_rise); end
    end
    rdy = 1; tick();
    total++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd2, 1'b1}) begin bad++; $display("FAIL bp_next got=v%b ch%0d r%b exp=v1 ch2 r1", evt_valid, evt_ch, evt_rise); end
    rdy = 0;
  endtask
`ifdef EDGE_ARB_FALLING_EN
  task automatic test_older_first();
    apply_reset();
    d = 4'b1000; tick();
    d = 4'b0000; tick(); tick();
    total++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd3, 1'b1}) begin bad++; $display("FAIL old_rise got=v%b ch%0d r%b exp=v1 ch3 r1", evt_valid, evt_ch, evt_rise); end
    rdy = 1; tick();
    total++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd3, 1'b0}) begin bad++; $display("FAIL old_fall got=v%b ch%0d r%b exp=v1 ch3 r0", evt_valid, evt_ch, evt_rise); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL old_ovf got=%b exp=0000", ovf); end
    rdy = 0;
  endtask
`endif
  task automatic test_overflow();
    apply_reset();
    d = 4'b0010; tick(); tick();
    d = 4'b0011; tick();
    d = 4'b0010; tick();
    d = 4'b0011; tick();
    total++; if (ovf !== 4'b0001) begin bad++; $display("FAIL ovf_set got=%b exp=0001", ovf); end
    clr = 4'b0001; tick(); clr = '0;
    total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL ovf_clr got=%b exp=0000", ovf); end
    d = 4'b0010; tick();
    d = 4'b0011; clr = 4'b0001; tick(); clr = '0;
    total++; if (ovf !== 4'b0001) begin bad++; $display("FAIL ovf_set_wins got=%b exp=0001", ovf); end
  endtask
  task automatic test_reset_mid();
    apply_reset();
    d = 4'b1111; tick(); tick();
    total++; if ({evt_valid, evt_ch} !== {1'b1, 2'd0}) begin bad++; $display("FAIL mid_pre got=v%b ch%0d exp=v1 ch0", evt_valid, evt_ch); end
    rst = 1; tick();
    total++; if ({evt_valid, evt_ch, evt_rise, ovf} !== {1'b0, 2'd0, !FE, 4'b0000}) begin bad++; $display("FAIL mid_rst got=v%b ch%0d r%b ovf%b exp=v0 ch0 r%b ovf0000", evt_valid, evt_ch, evt_rise, ovf, !FE); end
    rst = 0; d = '0; rdy = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_%0d got=%b exp=0", i, evt_valid); end
    end
  endtask
  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      d = d ^ N'($urandom() & $urandom());
      rdy = (i % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0) ? N'($urandom()) : '0;
      rst = ($urandom_range(0, 249) == 0);
      tick();
      total++; if (evt_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, evt_valid, m_valid); end
      if (m_valid) begin
        total++; if ({evt_ch, evt_rise} !== {W'(m_ch), m_rise}) begin bad++; $display("FAIL rnd_evt cyc=%0d got=ch%0d r%b exp=ch%0d r%b", i, evt_ch, evt_rise, m_ch, m_rise); end
      end
      total++; if (ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, ovf, m_ovf); end
    end
    rst = 0;
  endtask
  initial begin
    test_reset();
    test_release();
    test_back_to_back();
    test_backpressure();
`ifdef EDGE_ARB_FALLING_EN
    test_older_first();
`endif
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
